// File: rtl/wir_param_if.sv
// Control and data bundle between the wrapper serial control (WSC) side and the WIR.
// The master drives WSC controls and instruction inputs. The slave (the WIR) drives decodes back.
interface wir_param_if #(
    parameter int IR_WIDTH = 3
);
    logic                SelectWIR;
    logic                CaptureWR;
    logic                ShiftWR;
    logic                UpdateWR;
    logic                WPSE;
    logic                wir_wsi;
    logic [IR_WIDTH-1:0] wpi_instr;

    logic                wir_wso;
    logic [IR_WIDTH-1:0] wir_instr;
    logic                wir_bypass;
    logic                wir_extest;
    logic                wir_intest;
    logic                wir_preload;
    logic                wir_clamp;
    logic                wir_wbr_sel;
    logic                hold_inputs;
    logic                hold_outputs;
    logic                wir_err;

    modport master (
        output SelectWIR, CaptureWR, ShiftWR, UpdateWR, WPSE, wir_wsi, wpi_instr,
        input  wir_wso, wir_instr, wir_bypass, wir_extest, wir_intest, wir_preload,
               wir_clamp, wir_wbr_sel, hold_inputs, hold_outputs, wir_err
    );

    modport slave (
        input  SelectWIR, CaptureWR, ShiftWR, UpdateWR, WPSE, wir_wsi, wpi_instr,
        output wir_wso, wir_instr, wir_bypass, wir_extest, wir_intest, wir_preload,
               wir_clamp, wir_wbr_sel, hold_inputs, hold_outputs, wir_err
    );
endinterface

// File: rtl/wir_param.sv
// Parametrised P1500 Wrapper Instruction Register with a serial and a parallel (WPSE) load.
// Unknown opcodes decode as BYPASS and set a sticky error bit that the next Capture reports and clears.
module wir_param #(
    parameter int          IR_WIDTH   = 3,
    parameter int unsigned OP_BYPASS  = 0,
    parameter int unsigned OP_EXTEST  = 1,
    parameter int unsigned OP_INTEST  = 2,
    parameter int unsigned OP_PRELOAD = 3,
    parameter int unsigned OP_CLAMP   = 4
) (
    input  logic WRCK,
    input  logic WRST,
    wir_param_if.slave wir
);

    logic [IR_WIDTH-1:0] shift_q, shift_d;
    logic [IR_WIDTH-1:0] upd_q, upd_d;
    logic                err_q, err_d;
    logic [IR_WIDTH-1:0] loadVal;

    function automatic logic isValid(input logic [IR_WIDTH-1:0] op);
        return (op == IR_WIDTH'(OP_BYPASS))  || (op == IR_WIDTH'(OP_EXTEST)) ||
               (op == IR_WIDTH'(OP_INTEST))  || (op == IR_WIDTH'(OP_PRELOAD)) ||
               (op == IR_WIDTH'(OP_CLAMP));
    endfunction

    always_ff @(posedge WRCK or posedge WRST) begin
        if (WRST) begin
            shift_q <= '0;
            upd_q   <= IR_WIDTH'(OP_BYPASS);
            err_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            upd_q   <= upd_d;
            err_q   <= err_d;
        end
    end

    // Update samples the pre-edge shift register, so it may share an edge with Capture/Shift.
    // An invalid Update sets err after Capture's clear, so set wins on a shared edge.
    always_comb begin
        shift_d = shift_q;
        upd_d   = upd_q;
        err_d   = err_q;
        loadVal = wir.WPSE ? wir.wpi_instr : shift_q;
        if (wir.SelectWIR) begin
            if (wir.CaptureWR) begin
                shift_d    = '0;
                shift_d[0] = 1'b1;
                shift_d[2] = err_q;
                err_d      = 1'b0;
            end else if (wir.ShiftWR) begin
                shift_d = {wir.wir_wsi, shift_q[IR_WIDTH-1:1]};
            end
            if (wir.UpdateWR) begin
                upd_d = loadVal;
                if (!isValid(loadVal)) begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        wir.wir_wso      = shift_q[0];
        wir.wir_instr    = upd_q;
        wir.wir_err      = err_q;
        wir.wir_extest   = (upd_q == IR_WIDTH'(OP_EXTEST));
        wir.wir_intest   = (upd_q == IR_WIDTH'(OP_INTEST));
        wir.wir_preload  = (upd_q == IR_WIDTH'(OP_PRELOAD));
        wir.wir_clamp    = (upd_q == IR_WIDTH'(OP_CLAMP));
        wir.wir_bypass   = (upd_q == IR_WIDTH'(OP_BYPASS)) || !isValid(upd_q);
        wir.wir_wbr_sel  = wir.wir_extest | wir.wir_intest | wir.wir_preload;
        wir.hold_inputs  = wir.wir_intest;
        wir.hold_outputs = wir.wir_extest | wir.wir_clamp;
    end

endmodule

// File: tb/tb_wir_param.sv
// Directed bench for wir_param: a 3-bit default instance and a 5-bit instance with a remapped EXTEST.
// Expected output words go into a scoreboard queue when stimulus is driven and are popped after the edge.
module tb_wir_param;

    logic WRCK;
    logic WRST;

    wir_param_if #(.IR_WIDTH(3)) a3 ();
    wir_param_if #(.IR_WIDTH(5)) a5 ();

    wir_param #(.IR_WIDTH(3)) dut3 (
        .WRCK (WRCK),
        .WRST (WRST),
        .wir  (a3.slave)
    );

    wir_param #(.IR_WIDTH(5), .OP_EXTEST(32'h11)) dut5 (
        .WRCK (WRCK),
        .WRST (WRST),
        .wir  (a5.slave)
    );

    initial WRCK = 1'b0;
    always #5 WRCK = ~WRCK;

    // Decode field order: bypass, extest, intest, preload, clamp, wbr_sel, hold_inputs, hold_outputs
    localparam logic [7:0] D_BYP = 8'b1000_0000;
    localparam logic [7:0] D_EXT = 8'b0100_0101;
    localparam logic [7:0] D_INT = 8'b0010_0110;
    localparam logic [7:0] D_CLP = 8'b0000_1001;

    typedef struct {
        string       tag;
        logic [14:0] exp;
    } sbEntry_t;

    sbEntry_t    sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [14:0] obs3, obs5;

    assign obs3 = {2'b00, a3.wir_instr, a3.wir_bypass, a3.wir_extest, a3.wir_intest,
                   a3.wir_preload, a3.wir_clamp, a3.wir_wbr_sel, a3.hold_inputs,
                   a3.hold_outputs, a3.wir_err, a3.wir_wso};
    assign obs5 = {a5.wir_instr, a5.wir_bypass, a5.wir_extest, a5.wir_intest,
                   a5.wir_preload, a5.wir_clamp, a5.wir_wbr_sel, a5.hold_inputs,
                   a5.hold_outputs, a5.wir_err, a5.wir_wso};

    function automatic logic [14:0] vec(input logic [4:0] instr, input logic [7:0] dec,
                                        input logic err, input logic wso);
        return {instr, dec, err, wso};
    endfunction

    task automatic tick();
        @(posedge WRCK);
        #1;
    endtask

    // Drives one instance; the other is deselected so it must hold its state.
    task automatic applyStimulus(input bit toWide, input logic sel, input logic cap,
                                 input logic sh, input logic upd, input logic wpse,
                                 input logic wsi, input logic [4:0] wpi);
        a3.SelectWIR = toWide ? 1'b0 : sel;
        a3.CaptureWR = cap;
        a3.ShiftWR   = sh;
        a3.UpdateWR  = upd;
        a3.WPSE      = wpse;
        a3.wir_wsi   = wsi;
        a3.wpi_instr = wpi[2:0];
        a5.SelectWIR = toWide ? sel : 1'b0;
        a5.CaptureWR = cap;
        a5.ShiftWR   = sh;
        a5.UpdateWR  = upd;
        a5.WPSE      = wpse;
        a5.wir_wsi   = wsi;
        a5.wpi_instr = wpi;
    endtask

    task automatic pushExpected(input string tag, input logic [14:0] e);
        sbEntry_t ent;
        ent.tag = tag;
        ent.exp = e;
        sb.push_back(ent);
    endtask

    task automatic checkOutput(input logic [14:0] obs);
        sbEntry_t ent;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("[TB] FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            ent = sb.pop_front();
            assert (obs === ent.exp) else begin
                bad++;
                $error("[TB] FAIL %s observed=%h expected=%h", ent.tag, obs, ent.exp);
            end
        end
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        WRST = 1'b1;
        #12;
        pushExpected("reset3", vec(5'd0, D_BYP, 1'b0, 1'b0));
        checkOutput(obs3);
        pushExpected("reset5", vec(5'd0, D_BYP, 1'b0, 1'b0));
        checkOutput(obs5);
        @(negedge WRCK);
        WRST = 1'b0;

        // Serial load of INTEST (0,1,0 LSB first), then Update.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        pushExpected("shift_before_update", vec(5'd0, D_BYP, 1'b0, 1'b0));
        tick();
        checkOutput(obs3);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        pushExpected("serial_intest", vec(5'd2, D_INT, 1'b0, 1'b0));
        tick();
        checkOutput(obs3);

        // Capture then two shifts: wso reads 1,0,0.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        pushExpected("capture_bit0", vec(5'd2, D_INT, 1'b0, 1'b1));
        tick();
        checkOutput(obs3);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        pushExpected("capture_bit1", vec(5'd2, D_INT, 1'b0, 1'b0));
        tick();
        checkOutput(obs3);
        pushExpected("capture_bit2", vec(5'd2, D_INT, 1'b0, 1'b0));
        tick();
        checkOutput(obs3);

        // Serial invalid 3'b111, Update, then Capture readout 1,0,1 with err cleared.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0);
        tick();
        tick();
        pushExpected("shift_ones", vec(5'd2, D_INT, 1'b0, 1'b1));
        tick();
        checkOutput(obs3);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        pushExpected("invalid_update", vec(5'd7, D_BYP, 1'b1, 1'b1));
        tick();
        checkOutput(obs3);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        pushExpected("err_capture_b0", vec(5'd7, D_BYP, 1'b0, 1'b1));
        tick();
        checkOutput(obs3);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        pushExpected("err_capture_b1", vec(5'd7, D_BYP, 1'b0, 1'b0));
        tick();
        checkOutput(obs3);
        pushExpected("err_capture_b2", vec(5'd7, D_BYP, 1'b0, 1'b1));
        tick();
        checkOutput(obs3);

        // Parallel CLAMP load; shift register (001) must be untouched.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd4);
        pushExpected("parallel_clamp", vec(5'd4, D_CLP, 1'b0, 1'b1));
        tick();
        checkOutput(obs3);

        // Invalid parallel Update on the same edge as Capture: set wins.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd7);
        pushExpected("invalid_with_capture", vec(5'd7, D_BYP, 1'b1, 1'b1));
        tick();
        checkOutput(obs3);

        // Deselected with every enable high: nothing may change.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd2);
        for (int i = 0; i < 5; i++) begin
            pushExpected("gated_hold", vec(5'd7, D_BYP, 1'b1, 1'b1));
            tick();
            checkOutput(obs3);
        end

        // Async reset in the middle of a shift sequence.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0);
        tick();
        tick();
        pushExpected("pre_reset_shift", vec(5'd7, D_BYP, 1'b1, 1'b1));
        tick();
        checkOutput(obs3);
        WRST = 1'b1;
        #1;
        pushExpected("async_reset", vec(5'd0, D_BYP, 1'b0, 1'b0));
        checkOutput(obs3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        @(negedge WRCK);
        WRST = 1'b0;

        // 5-bit instance: serial load of EXTEST = 5'h11 (1,0,0,0,1 LSB first).
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        tick();
        tick();
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0);
        pushExpected("wide_shift_done", vec(5'd0, D_BYP, 1'b0, 1'b1));
        tick();
        checkOutput(obs5);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        pushExpected("wide_extest", vec(5'h11, D_EXT, 1'b0, 1'b1));
        tick();
        checkOutput(obs5);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        pushExpected("wide_capture_b0", vec(5'h11, D_EXT, 1'b0, 1'b1));
        tick();
        checkOutput(obs5);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        pushExpected("wide_capture_b1", vec(5'h11, D_EXT, 1'b0, 1'b0));
        tick();
        checkOutput(obs5);
        pushExpected("narrow_held_while_wide", vec(5'd0, D_BYP, 1'b0, 1'b0));
        checkOutput(obs3);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
